// File: rtl/demux4_stream_32bit.sv
// One-deep-per-lane stream demultiplexer: routes each accepted word to one of four output lanes.
// Optional build macro DEMUX_RR_EN selects the target lane with a round-robin pointer instead of in_sel.
module demux4_stream_32bit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_sel,
    output logic [3:0]        out_valid,
    input  logic [3:0]        out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    output logic              busy
);

    localparam int unsigned LANES = 4;

    logic [LANES-1:0]  valid_q;
    logic [DATA_W-1:0] data_q [LANES];
    logic [1:0]        tgt;
    logic              accept;
    logic [LANES-1:0]  fill;
    logic [LANES-1:0]  drain;

`ifdef DEMUX_RR_EN
    logic [1:0] ptr_q;
    logic [1:0] unused_sel;

    assign tgt        = ptr_q;
    assign unused_sel = in_sel;
`else
    assign tgt = in_sel;
`endif

    // A full lane can take a new word only when its consumer drains it in the same cycle.
    assign in_ready = rst_n & (~valid_q[tgt] | out_ready[tgt]);
    assign accept   = in_valid & in_ready;
    assign fill     = accept ? (LANES'(1) << tgt) : '0;
    assign drain    = valid_q & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < LANES; k++) begin
                data_q[k] <= '0;
            end
`ifdef DEMUX_RR_EN
            ptr_q <= '0;
`endif
        end else begin
            valid_q <= fill | (valid_q & ~drain);
            for (int k = 0; k < LANES; k++) begin
                if (fill[k]) begin
                    data_q[k] <= in_data;
                end
            end
`ifdef DEMUX_RR_EN
            ptr_q <= ptr_q + 2'(accept);
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign busy      = |valid_q;

endmodule
